// File: rtl/dcm_pkg.sv
// Shared defaults and the half-period helper for the multi-channel divider.
// Pure declarations; no logic, no latency, no flow control.
package dcm_pkg;

  localparam int unsigned DEF_SEL_W     = 3;
  localparam int unsigned DEF_CNT_W     = 32;
  localparam int unsigned DEF_BASE_HALF = 5000000;
  localparam int unsigned DEF_REF_HALF  = 5000000;

  // Callers truncate the 64-bit result to their own counter width.
  function automatic logic [63:0] half_period(input logic [7:0]  prog,
                                              input logic [63:0] base = 64'(DEF_BASE_HALF));
    return base << prog;
  endfunction

endpackage

// File: rtl/dcm_multi_if.sv
// Program/enable inputs and divided-clock outputs of dcm_multi, grouped as one bus.
// Wires only; every output is driven from a register inside the divider.
interface dcm_multi_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned SEL_W  = 3
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                      update;
  logic [CH_W-1:0]           ch_sel;
  logic [SEL_W-1:0]          prog;
  logic [NUM_CH-1:0]         enable;
  logic [NUM_CH*SEL_W-1:0]   prog_out;
  logic [NUM_CH-1:0]         pending;
  logic [NUM_CH-1:0]         clk_out;
  logic [NUM_CH-1:0]         tick;
  logic                      ref_clk;

  modport master (
    output update, ch_sel, prog, enable,
    input  prog_out, pending, clk_out, tick, ref_clk
  );

  modport slave (
    input  update, ch_sel, prog, enable,
    output prog_out, pending, clk_out, tick, ref_clk
  );

endinterface

// File: rtl/dcm_multi_clk_div_ch.sv
// One programmable divider channel with glitch-free rate switching at the end of a full period.
// Outputs registered, one clk after the causing edge; no backpressure (free-running).
module clk_div_ch
  import dcm_pkg::*;
#(
  parameter int unsigned SEL_W     = DEF_SEL_W,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned BASE_HALF = DEF_BASE_HALF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [SEL_W-1:0] wr_prog,
  output logic             clk_out,
  output logic             tick,
  output logic             pend,
  output logic [SEL_W-1:0] prog_act
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] limit;
  logic [SEL_W-1:0] pend_prog;
  logic [SEL_W-1:0] pend_prog_nxt;
  logic [SEL_W-1:0] prog_act_nxt;
  logic             clk_out_nxt;
  logic             tick_nxt;
  logic             pend_nxt;
  logic             wrap;
  logic             apply;

  assign half  = CNT_W'(half_period(8'(prog_act), 64'(BASE_HALF)));
  assign limit = half - CNT_W'(1);
  // >= rather than == so a counter left above a shorter limit still wraps.
  assign wrap  = (cnt >= limit);

  always_comb begin
    cnt_nxt       = cnt;
    clk_out_nxt   = clk_out;
    tick_nxt      = 1'b0;
    prog_act_nxt  = prog_act;
    pend_prog_nxt = pend_prog;
    pend_nxt      = pend;
    apply         = 1'b0;

    if (!en) begin
      cnt_nxt     = '0;
      clk_out_nxt = 1'b0;
      apply       = pend;
    end else if (wrap) begin
      cnt_nxt     = '0;
      clk_out_nxt = ~clk_out;
      tick_nxt    = ~clk_out;
      // Only a falling toggle closes a full period, so the new rate starts with a low phase.
      apply       = clk_out & pend;
    end else begin
      cnt_nxt     = cnt + CNT_W'(1);
    end

    if (apply) begin
      prog_act_nxt = pend_prog;
      pend_nxt     = 1'b0;
    end

    // A write landing on the apply edge keeps the new value pending.
    if (wr) begin
      pend_prog_nxt = wr_prog;
      pend_nxt      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      prog_act  <= '0;
      pend_prog <= '0;
      pend      <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      clk_out   <= clk_out_nxt;
      tick      <= tick_nxt;
      prog_act  <= prog_act_nxt;
      pend_prog <= pend_prog_nxt;
      pend      <= pend_nxt;
    end
  end

endmodule

// File: rtl/dcm_multi.sv
// NUM_CH programmable clock dividers plus a fixed reference divider, with write decode and packing.
// All outputs registered (one clk); no backpressure, writes to an unmapped channel are dropped.
module dcm_multi
  import dcm_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned SEL_W     = DEF_SEL_W,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned BASE_HALF = DEF_BASE_HALF,
  parameter int unsigned REF_HALF  = DEF_REF_HALF
) (
  input  logic        clk,
  input  logic        rst,
  dcm_multi_if.slave  bus
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]       ch_wr;
  logic [NUM_CH-1:0]       ch_clk;
  logic [NUM_CH-1:0]       ch_tick;
  logic [NUM_CH-1:0]       ch_pend;
  logic [NUM_CH*SEL_W-1:0] ch_prog;

  logic [CNT_W-1:0]        ref_cnt;
  logic                    ref_q;
  logic [CNT_W-1:0]        ref_limit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // An out-of-range ch_sel matches no channel.
    assign ch_wr[i] = bus.update && (bus.ch_sel == CH_W'(i));

    clk_div_ch #(
      .SEL_W     (SEL_W),
      .CNT_W     (CNT_W),
      .BASE_HALF (BASE_HALF)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.enable[i]),
      .wr       (ch_wr[i]),
      .wr_prog  (bus.prog),
      .clk_out  (ch_clk[i]),
      .tick     (ch_tick[i]),
      .pend     (ch_pend[i]),
      .prog_act (ch_prog[i*SEL_W +: SEL_W])
    );
  end

  assign ref_limit = CNT_W'(REF_HALF) - CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt <= '0;
      ref_q   <= 1'b0;
    end else if (ref_cnt >= ref_limit) begin
      ref_cnt <= '0;
      ref_q   <= ~ref_q;
    end else begin
      ref_cnt <= ref_cnt + CNT_W'(1);
    end
  end

  assign bus.clk_out  = ch_clk;
  assign bus.tick     = ch_tick;
  assign bus.pending  = ch_pend;
  assign bus.prog_out = ch_prog;
  assign bus.ref_clk  = ref_q;

endmodule
